// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD timing generator.
// Provides the RGB565 pixel type, the default 800x480 panel timing and the
// colour-bar palette used when LCD_TEST_PATTERN_EN is defined.
package lcd_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Default 800x480 panel timing (pixels / lines)
  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_H_FP     = 40;
  localparam int LCD_H_SYNC   = 48;
  localparam int LCD_H_BP     = 40;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_V_FP     = 13;
  localparam int LCD_V_SYNC   = 3;
  localparam int LCD_V_BP     = 29;
  localparam bit LCD_SYNC_POL = 1'b0;

  // Full-scale RGB565 colour-bar palette
  localparam rgb565_t COL_WHITE   = '{r: 5'h1F, g: 6'h3F, b: 5'h1F};
  localparam rgb565_t COL_YELLOW  = '{r: 5'h1F, g: 6'h3F, b: 5'h00};
  localparam rgb565_t COL_CYAN    = '{r: 5'h00, g: 6'h3F, b: 5'h1F};
  localparam rgb565_t COL_GREEN   = '{r: 5'h00, g: 6'h3F, b: 5'h00};
  localparam rgb565_t COL_MAGENTA = '{r: 5'h1F, g: 6'h00, b: 5'h1F};
  localparam rgb565_t COL_RED     = '{r: 5'h1F, g: 6'h00, b: 5'h00};
  localparam rgb565_t COL_BLUE    = '{r: 5'h00, g: 6'h00, b: 5'h1F};
  localparam rgb565_t COL_BLACK   = '{r: 5'h00, g: 6'h00, b: 5'h00};

  // Bar index (0 = leftmost) to colour
  function automatic rgb565_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Bus between the LCD timing generator, its pixel FIFO and the panel pins.
//
// Handshake: RDEN is a read request with no backpressure. Every cycle RDEN
// is high the FIFO must present the next pixel on RDDATA in the following
// cycle; there is no ready/valid pair because the panel cannot stall.
// START/STOP are single-cycle frame markers for the FIFO side.
interface lcd_timing_gen_if;
  logic        ENABLE;
  logic        START;
  logic        STOP;
  logic        RDEN;
  logic [15:0] RDDATA;
  logic        LCD_DE;
  logic        LCD_HSYNC;
  logic        LCD_VSYNC;
  logic [4:0]  LCD_R;
  logic [5:0]  LCD_G;
  logic [4:0]  LCD_B;
  logic [15:0] FRAME_COUNT;

  // Timing generator side
  modport master (
    input  ENABLE, RDDATA,
    output START, STOP, RDEN, LCD_DE, LCD_HSYNC, LCD_VSYNC,
           LCD_R, LCD_G, LCD_B, FRAME_COUNT
  );

  // FIFO / controller side
  modport slave (
    output ENABLE, RDDATA,
    input  START, STOP, RDEN, LCD_DE, LCD_HSYNC, LCD_VSYNC,
           LCD_R, LCD_G, LCD_B, FRAME_COUNT
  );
endinterface

// File: rtl/lcd_sync_counter.sv
// One axis of the raster: wrap counter over active/front porch/sync/back
// porch with a carry-in enable. Flags decode the current count.
module lcd_sync_counter #(
  parameter int ACTIVE  = 8,
  parameter int FP      = 2,
  parameter int SYNC    = 2,
  parameter int BP      = 2,
  parameter int RST_VAL = 0,
  parameter int W       = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_wrap,
  output logic         o_active,
  output logic         o_sync
);

  localparam int          TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
  localparam logic [W-1:0] START_V = W'(RST_VAL);
  localparam logic [31:0] ACT_END = 32'(ACTIVE);
  localparam logic [31:0] SYNC_LO = 32'(ACTIVE + FP);
  localparam logic [31:0] SYNC_HI = 32'(ACTIVE + FP + SYNC);

  logic [W-1:0] r_count;
  logic [31:0]  w_count32;

  // Count on carry-in, wrap at the end of the axis; clear returns to the idle point
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= START_V;
    end else if (i_clr) begin
      r_count <= START_V;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + W'(1);
    end
  end

  assign w_count32 = 32'(r_count);
  assign o_count   = r_count;
  assign o_wrap    = i_en & (r_count == LAST);
  assign o_active  = (w_count32 < ACT_END);
  assign o_sync    = (w_count32 >= SYNC_LO) && (w_count32 < SYNC_HI);

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: pixel read requests to a FIFO, panel
// DE/HSYNC/VSYNC/RGB, frame markers and a completed-frame counter.
// Optional macro LCD_TEST_PATTERN_EN replaces the FIFO pixel data with
// eight vertical colour bars (RDEN timing is unchanged).
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FP     = LCD_H_FP,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FP     = LCD_V_FP,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP,
  parameter bit SYNC_POL = LCD_SYNC_POL
) (
  input  logic              CLK_PXCLK,
  input  logic              RESET,
  lcd_timing_gen_if.master  bus
);

  localparam int   H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW        = $clog2(H_TOTAL);
  localparam int   VW        = $clog2(V_TOTAL);
  localparam logic SYNC_ACT  = SYNC_POL;
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [HW-1:0] w_h_count;
  logic [VW-1:0] w_v_count;
  logic          w_h_wrap, w_h_active, w_h_sync;
  logic          w_v_wrap_unused, w_v_active, w_v_sync;
  logic          w_clr;
  logic          w_start, w_stop_nat;

  logic          r_start, r_stop, r_rden, r_de;
  logic          r_hs_pipe, r_hs, r_vs_pipe, r_vs;
  logic [15:0]   r_frame;
  rgb565_t       w_rgb;

  // Dropping ENABLE parks both axes at the idle point (first blank line)
  assign w_clr = ~bus.ENABLE;

  lcd_sync_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .RST_VAL(0), .W(HW)
  ) u_h_cnt (
    .i_clk(CLK_PXCLK), .i_rst(RESET), .i_clr(w_clr), .i_en(bus.ENABLE),
    .o_count(w_h_count), .o_wrap(w_h_wrap),
    .o_active(w_h_active), .o_sync(w_h_sync)
  );

  lcd_sync_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .RST_VAL(V_ACTIVE), .W(VW)
  ) u_v_cnt (
    .i_clk(CLK_PXCLK), .i_rst(RESET), .i_clr(w_clr), .i_en(w_h_wrap),
    .o_count(w_v_count), .o_wrap(w_v_wrap_unused),
    .o_active(w_v_active), .o_sync(w_v_sync)
  );

  // START at the head of the last blank line, STOP just past the last pixel
  assign w_start    = (32'(w_h_count) == 32'd0) &&
                      (32'(w_v_count) == 32'(V_TOTAL - 1));
  assign w_stop_nat = (32'(w_h_count) == 32'(H_ACTIVE)) &&
                      (32'(w_v_count) == 32'(V_ACTIVE - 1));

  // Registered frame markers, read request and the one-cycle panel pipeline
  always_ff @(posedge CLK_PXCLK or posedge RESET) begin
    if (RESET) begin
      r_start   <= 1'b0;
      r_stop    <= 1'b0;
      r_rden    <= 1'b0;
      r_de      <= 1'b0;
      r_hs_pipe <= SYNC_IDLE;
      r_hs      <= SYNC_IDLE;
      r_vs_pipe <= SYNC_IDLE;
      r_vs      <= SYNC_IDLE;
      r_frame   <= 16'd0;
    end else if (!bus.ENABLE) begin
      // Aborting inside the active rows tells the FIFO the frame is over;
      // the in-flight pixel is discarded. Partial frames are not counted.
      r_start   <= 1'b0;
      r_stop    <= w_v_active;
      r_rden    <= 1'b0;
      r_de      <= 1'b0;
      r_hs_pipe <= SYNC_IDLE;
      r_hs      <= SYNC_IDLE;
      r_vs_pipe <= SYNC_IDLE;
      r_vs      <= SYNC_IDLE;
    end else begin
      r_start   <= w_start;
      r_stop    <= w_stop_nat;
      r_rden    <= w_h_active & w_v_active;
      r_de      <= r_rden;
      r_hs_pipe <= w_h_sync ? SYNC_ACT : SYNC_IDLE;
      r_hs      <= r_hs_pipe;
      r_vs_pipe <= w_v_sync ? SYNC_ACT : SYNC_IDLE;
      r_vs      <= r_vs_pipe;
      if (w_stop_nat) begin
        r_frame <= r_frame + 16'd1;
      end
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  logic [2:0] w_bar_idx;
  logic [2:0] r_bar_read, r_bar_show;

  // Bar index of the pixel being read, only meaningful while h is active
  assign w_bar_idx = 3'((32'(w_h_count) * 32'd8) / 32'(H_ACTIVE));

  // Carry the bar index alongside RDEN -> LCD_DE
  always_ff @(posedge CLK_PXCLK or posedge RESET) begin
    if (RESET) begin
      r_bar_read <= 3'd0;
      r_bar_show <= 3'd0;
    end else if (!bus.ENABLE) begin
      r_bar_read <= 3'd0;
      r_bar_show <= 3'd0;
    end else begin
      r_bar_read <= w_bar_idx;
      r_bar_show <= r_bar_read;
    end
  end
`endif

  // Pixel colour: FIFO word (or bar colour) while DE, black otherwise
  always_comb begin
    w_rgb = '0;
    if (r_de) begin
`ifdef LCD_TEST_PATTERN_EN
      w_rgb = bar_colour(r_bar_show);
`else
      w_rgb = rgb565_t'(bus.RDDATA);
`endif
    end
  end

  assign bus.START       = r_start;
  assign bus.STOP        = r_stop;
  assign bus.RDEN        = r_rden;
  assign bus.LCD_DE      = r_de;
  assign bus.LCD_HSYNC   = r_hs;
  assign bus.LCD_VSYNC   = r_vs;
  assign bus.LCD_R       = w_rgb.r;
  assign bus.LCD_G       = w_rgb.g;
  assign bus.LCD_B       = w_rgb.b;
  assign bus.FRAME_COUNT = r_frame;

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line.
- H_FP, 40, horizontal front porch in pixels.
- H_SYNC, 48, HSYNC width in pixels.
- H_BP, 40, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 13, vertical front porch in lines.
- V_SYNC, 3, VSYNC width in lines.
- V_BP, 29, vertical back porch in lines.
- SYNC_POL, 0, active level of HSYNC and VSYNC.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK_PXCLK, in, 1, pixel clock; the only clock.
- RESET, in, 1, asynchronous reset, active-high.
- ENABLE, in, 1, 1 = generate timing; 0 = hold idle.
- START, out, 1, one-cycle pulse before frame: FIFO may prefetch.
- STOP, out, 1, one-cycle pulse after last active pixel.
- RDEN, out, 1, pixel read request to FIFO.
- RDDATA, in, 16, RGB565 pixel, valid the cycle after RDEN.
- LCD_DE, out, 1, data enable.
- LCD_HSYNC, out, 1, horizontal sync.
- LCD_VSYNC, out, 1, vertical sync.
- LCD_R, out, 5, red.
- LCD_G, out, 6, green.
- LCD_B, out, 5, blue.
- FRAME_COUNT, out, 16, completed-frame counter, wraps.

Function
REQ-003 SHALL keep counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is formed likewise.
REQ-004 SHALL increment h every enabled cycle; at H_TOTAL-1, h SHALL wrap to 0 and v SHALL advance; v SHALL wrap from V_TOTAL-1 to 0.
REQ-005 SHALL order regions as active, front porch, sync, back porch on both axes; hsync region is H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and the vsync region is defined the same way on v.
REQ-006 SHALL register RDEN high exactly for the cycles where h < H_ACTIVE and v < V_ACTIVE: H_ACTIVE*V_ACTIVE pulses per frame.
REQ-007 SHALL assert LCD_DE one cycle after each RDEN cycle, with {LCD_R,LCD_G,LCD_B} = RDDATA[15:11], RDDATA[10:5], RDDATA[4:0] sampled in that cycle.
REQ-008 SHALL drive RGB to 0 whenever LCD_DE = 0.
REQ-009 SHALL delay LCD_HSYNC and LCD_VSYNC by the same one cycle so they stay aligned with LCD_DE; the active level is SYNC_POL, the inactive level ~SYNC_POL.
REQ-010 SHALL pulse START for one cycle when h = 0 and v = V_TOTAL-1 (start of the last blank line).
REQ-011 SHALL pulse STOP for one cycle when h = H_ACTIVE and v = V_ACTIVE-1 (the cycle after the last RDEN).
REQ-012 SHALL increment FRAME_COUNT in the same cycle as STOP, wrapping 0xFFFF -> 0.
REQ-013 SHALL, when ENABLE = 0 while v < V_ACTIVE, pulse STOP once in that cycle; it SHALL then hold the reset state while ENABLE = 0.
REQ-014 SHALL, when ENABLE = 0 outside the active rows, hold the reset state without a STOP pulse.
REQ-015 SHALL, when ENABLE rises, resume from the reset state, so START precedes any RDEN.
REQ-016 SHALL NOT emit START and STOP in the same cycle under any parameter set with V_FP+V_SYNC+V_BP >= 1.

Reset
REQ-017 SHALL, on RESET = 1 (asynchronous), set h = 0, v = V_ACTIVE (first blank line), and FRAME_COUNT = 0.
REQ-018 SHALL, on RESET = 1, set START = STOP = RDEN = LCD_DE = 0, RGB = 0, and LCD_HSYNC = LCD_VSYNC = ~SYNC_POL.
REQ-019 SHALL, when RESET is asserted mid-frame, return to this state immediately without a STOP pulse; the FIFO's own RESET covers that case.

Configuration
REQ-020 SHALL, with LCD_TEST_PATTERN_EN defined, replace the RDDATA path with 8 vertical colour bars. Bar index = h*8/H_ACTIVE (integer). Colours in order: white, yellow, cyan, green, magenta, red, blue, black (RGB565 full scale).
REQ-021 SHALL, with LCD_TEST_PATTERN_EN defined, keep RDEN behaviour unchanged, so the FIFO drains normally.
REQ-022 SHALL, without LCD_TEST_PATTERN_EN, contain no pattern logic.

Structure
REQ-023 SHALL take the rgb565_t typedef, the default 800x480 timing constants, and the colour-bar constants from shared package lcd_pkg.
REQ-024 SHALL implement each axis with sub-module lcd_sync_counter, instantiated twice. It is a parameterised wrap counter with a carry-in enable, and outputs the count, wrap, active flag and sync flag.

Verification
REQ-025 SHALL cover these scenarios (params H 8/2/2/2, V 4/1/1/1, SYNC_POL = 0, ENABLE = 1):
- Release reset -> START at cycle 14*2 = 28 (v = 6, h = 0); first RDEN at cycle 42; 8 RDEN per line; 32 RDEN per frame.
- RDDATA = 16'hF800 on each RDEN+1 -> LCD_DE = 1, LCD_R = 31, LCD_G = 0, LCD_B = 0 in that cycle; RGB = 0 when DE = 0.
- Full frame -> STOP exactly 1 cycle after the 32nd RDEN; FRAME_COUNT = 1; LCD_HSYNC low for 2 cycles at h = 10..11 (delayed 1); LCD_VSYNC low for line v = 5.
- ENABLE = 0 at line 2, pixel 3 -> single STOP pulse, RDEN = 0 next cycle; ENABLE = 1 later -> START 28 cycles later, then RDEN at the line 0 start.
- Assert RESET mid-line -> all outputs at reset values in the same cycle; no STOP pulse.
- With LCD_TEST_PATTERN_EN -> pixels 0..7 of each line = FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
